// File: rtl/power_test_pkg.sv
// Shared definitions for the power-load tile: mode codes, ui_in field positions,
// lane control struct and LFSR tap/seed helpers.
package power_test_pkg;

  localparam logic [1:0] MODE_IDLE   = 2'b00;
  localparam logic [1:0] MODE_TOGGLE = 2'b01;
  localparam logic [1:0] MODE_ADD    = 2'b10;
  localparam logic [1:0] MODE_LFSR   = 2'b11;

  localparam int UI_MODE_LSB    = 0;
  localparam int UI_MASK_LSB    = 2;
  localparam int UI_CNT_SEL_BIT = 6;
  localparam int UI_CLEAR_BIT   = 7;
  localparam int MAX_LANES      = 4;

  typedef struct packed {
    logic [1:0] mode;
    logic       lane_en;
    logic       clear;
  } lane_ctrl_t;

  function automatic logic [15:0] lfsr_taps(input int width);
    return (width == 16) ? 16'hB400 : 16'h00B8;
  endfunction

  // Seeds are lane+1 so no lane ever starts in the all-zero lock-up state.
  function automatic logic [15:0] lfsr_seed(input int lane);
    return 16'(lane + 1);
  endfunction

endpackage

// File: rtl/power_load_lane.sv
// One activity lane: an accumulator plus a right-shifting Galois LFSR, updated by
// the shared mode/clear controls when this lane is enabled.
module power_load_lane
  import power_test_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int LANE_IDX = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  lane_ctrl_t       ctrl,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc
);

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));
  localparam logic [WIDTH-1:0] SEED = WIDTH'(lfsr_seed(LANE_IDX));

  logic [WIDTH-1:0] lfsr, lfsr_nxt;

  assign lfsr_nxt = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);

  // Clear beats mode and ignores lane_en so every lane restarts together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      lfsr <= SEED;
    end else if (ctrl.clear) begin
      acc  <= '0;
      lfsr <= SEED;
    end else if (ctrl.lane_en) begin
      case (ctrl.mode)
        MODE_TOGGLE: acc <= ~acc;
        MODE_ADD:    acc <= acc + operand;
        MODE_LFSR: begin
          lfsr <= lfsr_nxt;
          acc  <= lfsr_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/tt_um_power_load.sv
// Power-stress generator top: LANES switching lanes, masked XOR checksum through a
// DEPTH-stage pipe onto uo_out. Define POWER_LOAD_CYCLE_CNT_EN for the activity counter on uio.
module tt_um_power_load
  import power_test_pkg::*;
#(
  parameter int LANES = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [1:0]             mode;
  logic [LANES-1:0]       mask;
  logic                   clear;
  logic [WIDTH-1:0]       operand;
  logic [LANES-1:0][WIDTH-1:0] lane_acc;
  logic [WIDTH-1:0]       chk_d;
  logic [DEPTH-1:0][WIDTH-1:0] pipe;

  assign mode    = ui_in[UI_MODE_LSB +: 2];
  assign mask    = ui_in[UI_MASK_LSB +: LANES];
  assign clear   = ena & ui_in[UI_CLEAR_BIT];
  assign operand = WIDTH'(uio_in);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lane_ctrl_t ctrl;
    assign ctrl = '{mode: mode, lane_en: ena & mask[g], clear: clear};

    power_load_lane #(.WIDTH(WIDTH), .LANE_IDX(g)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .ctrl    (ctrl),
      .operand (operand),
      .acc     (lane_acc[g])
    );
  end

  always_comb begin
    chk_d = '0;
    for (int i = 0; i < LANES; i++)
      if (mask[i]) chk_d ^= lane_acc[i];
  end

  // Pipe is deliberately left out of clear so it drains the pre-clear values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe <= '0;
    end else begin
      pipe[0] <= chk_d;
      for (int k = 1; k < DEPTH; k++) pipe[k] <= pipe[k-1];
    end
  end

  assign uo_out = pipe[DEPTH-1][7:0];

`ifdef POWER_LOAD_CYCLE_CNT_EN
  logic [15:0] cnt;
  logic [7:0]  cnt_byte_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (ena && mode != MODE_IDLE && cnt != 16'hFFFF) begin
      cnt <= cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_byte_q <= '0;
    else     cnt_byte_q <= ui_in[UI_CNT_SEL_BIT] ? cnt[15:8] : cnt[7:0];
  end

  assign uio_out = cnt_byte_q;
  assign uio_oe  = 8'hFF;
`else
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;
`endif

  logic unused_ok;
  assign unused_ok = ^{pipe[DEPTH-1], ui_in};

endmodule

// File: tb/tb_tt_um_power_load.sv
// Directed bench for tt_um_power_load (LANES=4, WIDTH=8, DEPTH=2): vector table plus
// hand sequences for wrap, async reset and the optional counter.
module tb_tt_um_power_load;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  wire  [7:0] uo_out, uio_out, uio_oe;

  tt_um_power_load #(.LANES(4), .WIDTH(8), .DEPTH(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit         rst_before;
    logic       ena;
    logic [7:0] ui;
    logic [7:0] uio;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t vt[$];

  function automatic void add(bit r, logic e, logic [7:0] ui, logic [7:0] uio,
                              logic [7:0] exp, string nm);
    vec_t v;
    v.rst_before = r; v.ena = e; v.ui = ui; v.uio = uio; v.exp = exp; v.name = nm;
    vt.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ena = 1'b0; ui_in = 8'h00; uio_in = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    // toggle, single lane: FF/00 alternation starting 2 edges after first toggle
    add(1, 1, 8'h05, 8'h00, 8'h00, "tog1");
    add(0, 1, 8'h05, 8'h00, 8'h00, "tog1");
    add(0, 1, 8'h05, 8'h00, 8'hFF, "tog1");
    add(0, 1, 8'h05, 8'h00, 8'h00, "tog1");
    add(0, 1, 8'h05, 8'h00, 8'hFF, "tog1");
    // toggle, all four lanes in phase cancel out
    add(1, 1, 8'h3D, 8'h00, 8'h00, "tog4");
    add(0, 1, 8'h3D, 8'h00, 8'h00, "tog4");
    add(0, 1, 8'h3D, 8'h00, 8'h00, "tog4");
    add(0, 1, 8'h3D, 8'h00, 8'h00, "tog4");
    // add 03 five times then idle
    add(1, 1, 8'h06, 8'h03, 8'h00, "add");
    add(0, 1, 8'h06, 8'h03, 8'h00, "add");
    add(0, 1, 8'h06, 8'h03, 8'h03, "add");
    add(0, 1, 8'h06, 8'h03, 8'h06, "add");
    add(0, 1, 8'h06, 8'h03, 8'h09, "add");
    add(0, 1, 8'h04, 8'h03, 8'h0C, "add_idle");
    add(0, 1, 8'h04, 8'h03, 8'h0F, "add_idle");
    add(0, 1, 8'h04, 8'h03, 8'h0F, "add_idle");
    // lfsr lane 0, seed 01: B8,5C,2E,17,B3
    add(1, 1, 8'h07, 8'h00, 8'h00, "lfsr0");
    add(0, 1, 8'h07, 8'h00, 8'h00, "lfsr0");
    add(0, 1, 8'h07, 8'h00, 8'hB8, "lfsr0");
    add(0, 1, 8'h07, 8'h00, 8'h5C, "lfsr0");
    add(0, 1, 8'h07, 8'h00, 8'h2E, "lfsr0");
    add(0, 1, 8'h07, 8'h00, 8'h17, "lfsr0");
    add(0, 1, 8'h07, 8'h00, 8'hB3, "lfsr0");
    // lfsr lane 2, seed 03: B9,E4,72
    add(1, 1, 8'h13, 8'h00, 8'h00, "lfsr2");
    add(0, 1, 8'h13, 8'h00, 8'h00, "lfsr2");
    add(0, 1, 8'h13, 8'h00, 8'hB9, "lfsr2");
    add(0, 1, 8'h13, 8'h00, 8'hE4, "lfsr2");
    add(0, 1, 8'h13, 8'h00, 8'h72, "lfsr2");
    // add 10 x4, clear pulse, pipe drains to 00, then ena=0 freezes
    add(1, 1, 8'h06, 8'h10, 8'h00, "clr_add");
    add(0, 1, 8'h06, 8'h10, 8'h00, "clr_add");
    add(0, 1, 8'h06, 8'h10, 8'h10, "clr_add");
    add(0, 1, 8'h06, 8'h10, 8'h20, "clr_add");
    add(0, 1, 8'h86, 8'h10, 8'h30, "clr_pulse");
    add(0, 1, 8'h04, 8'h10, 8'h40, "clr_drain");
    add(0, 1, 8'h04, 8'h10, 8'h00, "clr_done");
    add(0, 1, 8'h06, 8'h10, 8'h00, "clr_resume");
    add(0, 1, 8'h06, 8'h10, 8'h00, "clr_resume");
    add(0, 0, 8'h06, 8'h10, 8'h10, "ena_off");
    add(0, 0, 8'h06, 8'h10, 8'h20, "ena_off");
    add(0, 0, 8'h06, 8'h10, 8'h20, "ena_frozen");
    add(0, 0, 8'h06, 8'h10, 8'h20, "ena_frozen");

    // reset with random inputs, then idle release
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ena = 1'b1; ui_in = 8'($urandom); uio_in = 8'($urandom);
      step();
      chk("rst_uo", uo_out, 8'h00);
      chk("rst_uio", uio_out, 8'h00);
    end
    ui_in = 8'h3C; uio_in = 8'($urandom);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_uo", uo_out, 8'h00);
    end

    foreach (vt[i]) begin
      if (vt[i].rst_before) do_reset();
      ena = vt[i].ena; ui_in = vt[i].ui; uio_in = vt[i].uio;
      step();
      chk(vt[i].name, uo_out, vt[i].exp);
`ifndef POWER_LOAD_CYCLE_CNT_EN
      chk("nocnt_uio_out", uio_out, 8'h00);
      chk("nocnt_uio_oe", uio_oe, 8'h00);
`endif
    end

    // 86 adds of 03 wrap to 02
    do_reset();
    ena = 1'b1; ui_in = 8'h06; uio_in = 8'h03;
    repeat (86) step();
    ui_in = 8'h04;
    repeat (2) step();
    chk("add_wrap", uo_out, 8'h02);

    // async reset mid-run, first update on first edge after release
    do_reset();
    ena = 1'b1; ui_in = 8'h05;
    repeat (3) step();
    chk("pre_rst", uo_out, 8'hFF);
    #2 rst = 1'b1;
    #1 chk("async_rst", uo_out, 8'h00);
    @(posedge clk);
    #1 rst = 1'b0;
    step(); chk("post_rst1", uo_out, 8'h00);
    step(); chk("post_rst2", uo_out, 8'h00);
    step(); chk("post_rst3", uo_out, 8'hFF);

`ifdef POWER_LOAD_CYCLE_CNT_EN
    do_reset();
    ena = 1'b1; ui_in = 8'h05;
    repeat (300) step();
    ui_in = 8'h04; step();
    chk("cnt_lo", uio_out, 8'h2C);
    ui_in = 8'h44; step();
    chk("cnt_hi", uio_out, 8'h01);
    chk("cnt_oe", uio_oe, 8'hFF);
    ui_in = 8'h84; step();
    ui_in = 8'h04; step();
    chk("cnt_clear", uio_out, 8'h00);
    ui_in = 8'h05;
    repeat (65540) step();
    ui_in = 8'h04; step();
    chk("cnt_sat_lo", uio_out, 8'hFF);
    ui_in = 8'h44; step();
    chk("cnt_sat_hi", uio_out, 8'hFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
